// File: rtl/fetch_unit.sv
// Parametrised PC / instruction-fetch stage.
// In-order memory requests, fall-through word FIFO, redirect flush.
module fetch_unit #(
  parameter int ADDR_W       = 16,
  parameter int INSTR_W      = 16,
  parameter int RESET_VECTOR = 10,
  parameter int PC_STEP      = 2,
  parameter int DEPTH        = 2
) (
  input  logic               Clock,
  input  logic               ResetN,
  input  logic               Enable,
  output logic               IMemReq,
  output logic [ADDR_W-1:0]  IMemAddr,
  input  logic               IMemValid,
  input  logic [INSTR_W-1:0] IMemData,
  input  logic               RedirectValid,
  input  logic [ADDR_W-1:0]  RedirectTarget,
  output logic               InstrValid,
  output logic [INSTR_W-1:0] Instr,
  output logic [ADDR_W-1:0]  InstrPC,
  input  logic               InstrReady,
  output logic               AlignErr
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LOWM = ADDR_W'(PC_STEP - 1);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] RVEC = ADDR_W'(RESET_VECTOR);
  localparam logic [CW:0]       DEP  = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [CW-1:0]       infl_q, infl_d;
  logic [CW-1:0]       drop_q, drop_d;
  logic [CW-1:0]       fcnt_q, fcnt_d;
  logic [PW-1:0]       frd_q, frd_d;
  logic [PW-1:0]       fwr_q, fwr_d;
  logic [PW-1:0]       srd_q, srd_d;
  logic [PW-1:0]       swr_q, swr_d;
  logic                align_q, align_d;
  logic [INSTR_W-1:0]  fdat_q [DEPTH];
  logic [ADDR_W-1:0]   fpc_q  [DEPTH];
  logic [ADDR_W-1:0]   spc_q  [DEPTH];

  logic fempty, rsp_acc, rsp_drop, issue;
  logic pop, fpush, fpop, rsp_any;

  assign fempty   = (fcnt_q == '0);
  assign rsp_acc  = IMemValid && (drop_q == '0) && (infl_q != '0);
  assign rsp_drop = IMemValid && (drop_q != '0);
  assign rsp_any  = IMemValid && ((drop_q != '0) || (infl_q != '0));
  assign issue    = (state_q == RUN) && Enable && !RedirectValid
                 && (({1'b0, infl_q} + {1'b0, fcnt_q}) < DEP);

  // Empty FIFO lets an arriving word fall straight through to decode.
  assign InstrValid = (!fempty || rsp_acc) && !RedirectValid;
  assign Instr      = fempty ? IMemData : fdat_q[frd_q];
  assign InstrPC    = fempty ? spc_q[srd_q] : fpc_q[frd_q];
  assign pop        = InstrValid && InstrReady;
  assign fpush      = rsp_acc && !RedirectValid && !(fempty && pop);
  assign fpop       = pop && !fempty;

  assign IMemReq  = issue;
  assign IMemAddr = pc_q;
  assign AlignErr = align_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (!Enable) state_d = HOLD;
      HOLD:    if (Enable) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    infl_d  = infl_q;
    drop_d  = drop_q;
    fcnt_d  = fcnt_q;
    frd_d   = frd_q;
    fwr_d   = fwr_q;
    srd_d   = srd_q;
    swr_d   = swr_q;
    align_d = align_q;
    if (RedirectValid) begin
      pc_d   = RedirectTarget & ~LOWM;
      infl_d = '0;
      drop_d = drop_q + infl_q - CW'(rsp_any);
      fcnt_d = '0;
      frd_d  = '0;
      fwr_d  = '0;
      srd_d  = '0;
      swr_d  = '0;
      if ((RedirectTarget & LOWM) != '0) align_d = 1'b1;
    end else begin
      if (issue) begin
        pc_d  = pc_q + STEP;
        swr_d = swr_q + PW'(1);
      end
      infl_d = infl_q + CW'(issue) - CW'(rsp_acc);
      drop_d = drop_q - CW'(rsp_drop);
      srd_d  = srd_q + PW'(rsp_acc);
      fwr_d  = fwr_q + PW'(fpush);
      frd_d  = frd_q + PW'(fpop);
      fcnt_d = fcnt_q + CW'(fpush) - CW'(fpop);
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= BOOT;
      pc_q    <= RVEC;
      infl_q  <= '0;
      drop_q  <= '0;
      fcnt_q  <= '0;
      frd_q   <= '0;
      fwr_q   <= '0;
      srd_q   <= '0;
      swr_q   <= '0;
      align_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      infl_q  <= infl_d;
      drop_q  <= drop_d;
      fcnt_q  <= fcnt_d;
      frd_q   <= frd_d;
      fwr_q   <= fwr_d;
      srd_q   <= srd_d;
      swr_q   <= swr_d;
      align_q <= align_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (fpush) begin
      fdat_q[fwr_q] <= IMemData;
      fpc_q[fwr_q]  <= spc_q[srd_q];
    end
    if (issue) spc_q[swr_q] <= pc_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit.
// Memory model returns ~address after a selectable latency.
module tb_fetch_unit;

  logic        Clock;
  logic        ResetN;
  logic        Enable;
  logic        IMemReq;
  logic [15:0] IMemAddr;
  logic        IMemValid;
  logic [15:0] IMemData;
  logic        RedirectValid;
  logic [15:0] RedirectTarget;
  logic        InstrValid;
  logic [15:0] Instr;
  logic [15:0] InstrPC;
  logic        InstrReady;
  logic        AlignErr;

  int checks = 0;
  int errors = 0;
  int lat = 1;
  logic        pv [8];
  logic [15:0] pa [8];
  logic [15:0] req_q [$];
  logic [15:0] acc_q [$];

  fetch_unit dut (
    .Clock(Clock),
    .ResetN(ResetN),
    .Enable(Enable),
    .IMemReq(IMemReq),
    .IMemAddr(IMemAddr),
    .IMemValid(IMemValid),
    .IMemData(IMemData),
    .RedirectValid(RedirectValid),
    .RedirectTarget(RedirectTarget),
    .InstrValid(InstrValid),
    .Instr(Instr),
    .InstrPC(InstrPC),
    .InstrReady(InstrReady),
    .AlignErr(AlignErr)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    logic        r;
    logic [15:0] a;
    r = IMemReq;
    a = IMemAddr;
    if (IMemReq) req_q.push_back(IMemAddr);
    if (InstrValid && InstrReady) acc_q.push_back(InstrPC);
    @(posedge Clock);
    #1;
    for (int i = 7; i > 0; i--) begin
      pv[i] = pv[i-1];
      pa[i] = pa[i-1];
    end
    pv[0] = r;
    pa[0] = a;
    IMemValid = pv[lat-1];
    IMemData  = ~pa[lat-1];
    #1;
  endtask

  task automatic do_reset(input int l);
    ResetN = 1'b0;
    Enable = 1'b1;
    InstrReady = 1'b1;
    RedirectValid = 1'b0;
    RedirectTarget = '0;
    lat = l;
    repeat (8) tick();
    ResetN = 1'b1;
    #1;
    req_q.delete();
    acc_q.delete();
  endtask

  task automatic test_reset();
    ResetN = 1'b0;
    Enable = 1'b1;
    InstrReady = 1'b1;
    RedirectValid = 1'b0;
    RedirectTarget = '0;
    IMemValid = 1'b0;
    IMemData = '0;
    for (int i = 0; i < 8; i++) begin
      pv[i] = 1'b0;
      pa[i] = '0;
    end
    repeat (8) tick();
    checks++;
    if (IMemReq !== 1'b0) begin
      errors++;
      $display("FAIL rst_req got %b exp 0", IMemReq);
    end
    checks++;
    if (InstrValid !== 1'b0) begin
      errors++;
      $display("FAIL rst_ivalid got %b exp 0", InstrValid);
    end
    checks++;
    if (AlignErr !== 1'b0) begin
      errors++;
      $display("FAIL rst_align got %b exp 0", AlignErr);
    end
    ResetN = 1'b1;
    #1;
    checks++;
    if (IMemReq !== 1'b0) begin
      errors++;
      $display("FAIL boot_req got %b exp 0", IMemReq);
    end
  endtask

  task automatic test_seq();
    logic [15:0] e;
    do_reset(1);
    tick();
    for (int k = 0; k < 4; k++) begin
      #1;
      e = 16'(10 + 2*k);
      checks++;
      if (IMemReq !== 1'b1 || IMemAddr !== e) begin
        errors++;
        $display("FAIL seq_addr k=%0d got %b/%h exp 1/%h",
                 k, IMemReq, IMemAddr, e);
      end
      if (k > 0) begin
        e = 16'(10 + 2*(k-1));
        checks++;
        if (InstrValid !== 1'b1 || InstrPC !== e || Instr !== ~e) begin
          errors++;
          $display("FAIL seq_pc k=%0d got %b/%h/%h exp 1/%h/%h",
                   k, InstrValid, InstrPC, Instr, e, ~e);
        end
      end
      tick();
    end
    checks++;
    if (AlignErr !== 1'b0) begin
      errors++;
      $display("FAIL seq_align got %b exp 0", AlignErr);
    end
  endtask

  task automatic test_stall();
    int nreq;
    nreq = 0;
    do_reset(1);
    tick();
    InstrReady = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      nreq += int'(IMemReq);
      if (k >= 2) begin
        checks++;
        if (IMemReq !== 1'b0) begin
          errors++;
          $display("FAIL stall_req k=%0d got %b exp 0", k, IMemReq);
        end
      end
      if (k >= 1) begin
        checks++;
        if (InstrValid !== 1'b1 || InstrPC !== 16'd10
            || Instr !== ~16'd10) begin
          errors++;
          $display("FAIL stall_head k=%0d got %b/%h/%h exp 1/000a/fff5",
                   k, InstrValid, InstrPC, Instr);
        end
      end
      tick();
    end
    checks++;
    if (nreq != 2) begin
      errors++;
      $display("FAIL stall_nreq got %0d exp 2", nreq);
    end
    InstrReady = 1'b1;
    repeat (3) tick();
    checks++;
    if (acc_q.size() != 3 || acc_q[0] !== 16'd10
        || acc_q[1] !== 16'd12 || acc_q[2] !== 16'd14) begin
      errors++;
      $display("FAIL stall_acc got n=%0d exp 10,12,14", acc_q.size());
    end
    checks++;
    if (req_q.size() < 3 || req_q[2] !== 16'd14) begin
      errors++;
      $display("FAIL stall_resume got n=%0d exp third req 000e",
               req_q.size());
    end
  endtask

  task automatic test_redirect();
    do_reset(3);
    tick();
    tick();
    RedirectValid = 1'b1;
    RedirectTarget = 16'h0040;
    #1;
    checks++;
    if (IMemReq !== 1'b0 || InstrValid !== 1'b0) begin
      errors++;
      $display("FAIL redir_cycle got %b/%b exp 0/0", IMemReq, InstrValid);
    end
    tick();
    RedirectValid = 1'b0;
    #1;
    checks++;
    if (IMemReq !== 1'b1 || IMemAddr !== 16'h0040
        || InstrValid !== 1'b0) begin
      errors++;
      $display("FAIL redir_c4 got %b/%h/%b exp 1/0040/0",
               IMemReq, IMemAddr, InstrValid);
    end
    tick();
    #1;
    checks++;
    if (IMemReq !== 1'b1 || IMemAddr !== 16'h0042
        || InstrValid !== 1'b0) begin
      errors++;
      $display("FAIL redir_c5 got %b/%h/%b exp 1/0042/0",
               IMemReq, IMemAddr, InstrValid);
    end
    tick();
    #1;
    checks++;
    if (InstrValid !== 1'b0) begin
      errors++;
      $display("FAIL redir_c6 got %b exp 0", InstrValid);
    end
    tick();
    #1;
    checks++;
    if (InstrValid !== 1'b1 || InstrPC !== 16'h0040
        || Instr !== ~16'h0040) begin
      errors++;
      $display("FAIL redir_pc0 got %b/%h/%h exp 1/0040/ffbf",
               InstrValid, InstrPC, Instr);
    end
    tick();
    #1;
    checks++;
    if (InstrValid !== 1'b1 || InstrPC !== 16'h0042) begin
      errors++;
      $display("FAIL redir_pc1 got %b/%h exp 1/0042", InstrValid, InstrPC);
    end
    tick();
  endtask

  task automatic test_align();
    do_reset(1);
    tick();
    RedirectValid = 1'b1;
    RedirectTarget = 16'h0041;
    #1;
    checks++;
    if (IMemReq !== 1'b0) begin
      errors++;
      $display("FAIL align_noreq got %b exp 0", IMemReq);
    end
    tick();
    RedirectValid = 1'b0;
    #1;
    checks++;
    if (AlignErr !== 1'b1 || IMemReq !== 1'b1 || IMemAddr !== 16'h0040) begin
      errors++;
      $display("FAIL align_set got %b/%b/%h exp 1/1/0040",
               AlignErr, IMemReq, IMemAddr);
    end
    tick();
    #1;
    checks++;
    if (InstrValid !== 1'b1 || InstrPC !== 16'h0040) begin
      errors++;
      $display("FAIL align_pc got %b/%h exp 1/0040", InstrValid, InstrPC);
    end
    RedirectValid = 1'b1;
    RedirectTarget = 16'h0080;
    #1;
    checks++;
    if (InstrValid !== 1'b0) begin
      errors++;
      $display("FAIL align_kill got %b exp 0", InstrValid);
    end
    tick();
    RedirectValid = 1'b0;
    #1;
    checks++;
    if (IMemReq !== 1'b1 || IMemAddr !== 16'h0080 || AlignErr !== 1'b1) begin
      errors++;
      $display("FAIL align_redir2 got %b/%h/%b exp 1/0080/1",
               IMemReq, IMemAddr, AlignErr);
    end
    tick();
    #1;
    checks++;
    if (InstrValid !== 1'b1 || InstrPC !== 16'h0080 || AlignErr !== 1'b1) begin
      errors++;
      $display("FAIL align_pc2 got %b/%h/%b exp 1/0080/1",
               InstrValid, InstrPC, AlignErr);
    end
    ResetN = 1'b0;
    #1;
    checks++;
    if (AlignErr !== 1'b0) begin
      errors++;
      $display("FAIL align_clr got %b exp 0", AlignErr);
    end
  endtask

  task automatic test_wrap();
    do_reset(1);
    tick();
    RedirectValid = 1'b1;
    RedirectTarget = 16'hFFFE;
    tick();
    RedirectValid = 1'b0;
    #1;
    checks++;
    if (IMemReq !== 1'b1 || IMemAddr !== 16'hFFFE) begin
      errors++;
      $display("FAIL wrap_a0 got %b/%h exp 1/fffe", IMemReq, IMemAddr);
    end
    tick();
    #1;
    checks++;
    if (IMemAddr !== 16'h0000 || InstrPC !== 16'hFFFE
        || InstrValid !== 1'b1) begin
      errors++;
      $display("FAIL wrap_a1 got %h/%h/%b exp 0000/fffe/1",
               IMemAddr, InstrPC, InstrValid);
    end
    tick();
    #1;
    checks++;
    if (IMemAddr !== 16'h0002 || InstrPC !== 16'h0000
        || InstrValid !== 1'b1) begin
      errors++;
      $display("FAIL wrap_a2 got %h/%h/%b exp 0002/0000/1",
               IMemAddr, InstrPC, InstrValid);
    end
    tick();
  endtask

  task automatic test_midreset();
    do_reset(2);
    tick();
    tick();
    #1;
    checks++;
    if (IMemReq !== 1'b1 || IMemAddr !== 16'd12) begin
      errors++;
      $display("FAIL mid_pre got %b/%h exp 1/000c", IMemReq, IMemAddr);
    end
    ResetN = 1'b0;
    #1;
    checks++;
    if (IMemReq !== 1'b0 || InstrValid !== 1'b0) begin
      errors++;
      $display("FAIL mid_async got %b/%b exp 0/0", IMemReq, InstrValid);
    end
    tick();
    ResetN = 1'b1;
    #1;
    checks++;
    if (InstrValid !== 1'b0 || IMemReq !== 1'b0) begin
      errors++;
      $display("FAIL mid_late got %b/%b exp 0/0", InstrValid, IMemReq);
    end
    tick();
    #1;
    checks++;
    if (IMemReq !== 1'b1 || IMemAddr !== 16'd10 || InstrValid !== 1'b0) begin
      errors++;
      $display("FAIL mid_first got %b/%h/%b exp 1/000a/0",
               IMemReq, IMemAddr, InstrValid);
    end
    tick();
    #1;
    checks++;
    if (InstrValid !== 1'b0) begin
      errors++;
      $display("FAIL mid_c5 got %b exp 0", InstrValid);
    end
    tick();
    #1;
    checks++;
    if (InstrValid !== 1'b1 || InstrPC !== 16'd10) begin
      errors++;
      $display("FAIL mid_c6 got %b/%h exp 1/000a", InstrValid, InstrPC);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_seq();
    test_stall();
    test_redirect();
    test_align();
    test_wrap();
    test_midreset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
